bsg_flow_credit_receiver: RTL and testbench
===========================================

Name: bsg_flow_credit_receiver

Overview:
- Receive-side endpoint of the credit flow-control link.
- The sender gates its transmit valid on its free-credit count. That count starts at els_p, drops by one on each enque and rises on each credit return.
- This block buffers incoming words in an els_p-entry FIFO and presents them to the local consumer with valid/yumi.
- Dequeued entries become credits that are returned to the sender in batches over a valid/ready credit channel.

Parameters:
- width_p, 8, data word width.
- els_p, 16, FIFO depth and total credit pool; must be a power of two, ≥2.
- credit_batch_p, 4, credits accumulated before a return is offered; 1..els_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  incoming word valid; no ready, space is guaranteed by credits
- data_i  in  width_p  incoming word
- v_o  out  1  FIFO head valid
- data_o  out  width_p  FIFO head word
- yumi_i  in  1  consumer dequeues head; legal only when v_o=1
- flush_i  in  1  level; return all pending credits regardless of batch size
- credit_v_o  out  1  credit return offer valid
- credit_count_o  out  $clog2(els_p+1)  credits carried by the current offer
- credit_ready_i  in  1  sender accepts the credit offer

Behaviour:
- Reset values: v_o=0, credit_v_o=0, credit_count_o=0; FIFO empty; pending credit counter=0; rd/wr pointers=0.
- FIFO write: on v_i=1 and not full, data_i is written at wr_ptr and wr_ptr advances modulo els_p.
- FIFO read: v_o=(occupancy≠0) and data_o=mem[rd_ptr], both from registered state with no bypass. A written word first appears on v_o one cycle after v_i. On yumi_i, rd_ptr advances.
- Occupancy counter: $clog2(els_p+1) bits, range 0..els_p, next = occ + write − yumi_i.
- Write when full, with or without simultaneous yumi: the word is dropped and occupancy is unchanged. This is a protocol violation, because credits can never permit it.
- yumi_i when v_o=0: ignored, no state change.
- Pending counter: $clog2(els_p+1) bits, counts dequeued-but-unreturned credits. Invariant: occupancy + pending + offered credits + sender free count = els_p.
- Offer slot is free when credit_v_o=0, or when credit_v_o=1 and credit_ready_i=1 in the same cycle (a back-to-back reload is allowed).
- Load rule: if the slot is free and either pending ≥ credit_batch_p, or flush_i=1 and pending>0, then next cycle:
  - credit_v_o=1;
  - credit_count_o = flush_i ? pending : credit_batch_p;
  - pending is reduced by that amount.
- The load decision uses pending before this cycle's yumi_i. The yumi increment is always applied the same cycle: pending_next = pending − loaded + yumi_i.
- Hold rule: while credit_v_o=1 and credit_ready_i=0, credit_v_o and credit_count_o stay stable.
- On accept with no reload, credit_v_o=0 and credit_count_o=0 next cycle.
- Credit latency: with credit_batch_p=1, flush_i=0 and credit_ready_i=1, credit_v_o rises 2 cycles after the yumi_i cycle (pending register, then offer register).
- Reset mid-operation: all state returns to reset values the next cycle and buffered data is discarded. The sender is reset in the same domain, so its count re-initialises to els_p.

Optional Feature:
- Macro: BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN.
- Defined: adds output error_o (1 bit, reset 0). error_o is sticky and is set the cycle after any dropped write (v_i while full) or any yumi_i while v_o=0. It is cleared only by reset_i.
- Undefined: no error_o port and no checking logic; drop/ignore behaviour is identical.

Decomposition:
- Shared package: count-width function or constant ($clog2(els_p+1)) and the pointer width constant.
- One natural sub-module: bsg_flow_credit_receiver_fifo (storage, pointers, occupancy).
- The credit batching/offer register stays in the top level.

Test Plan:
- Basic pass-through, default params, credit_ready_i=1: write 0xA1 at cycle 0, then v_o=1 and data_o=0xA1 at cycle 1; yumi at cycle 1; no credit_v_o, pending=1.
- Batching: write 4 words, yumi each on consecutive cycles 1..4 → exactly one credit_v_o pulse with credit_count_o=4, 2 cycles after the 4th yumi; pending=0 afterwards.
- Backpressure: reach batch, hold credit_ready_i=0 for 5 cycles while dequeuing 4 more → credit_count_o stays 4 and is stable; on ready, next cycle offers 4 again (back-to-back); total returned = 8.
- Flush: dequeue 3 words, then assert flush_i → credit_v_o with credit_count_o=3; flush_i with pending=0 → no offer.
- Full/overflow: fill 16 words, then drive v_i with data 0xFF → occupancy stays 16 and 0xFF is never read out; error_o=1 next cycle when the macro is defined.
- Reset mid-stream: with 7 words buffered and an offer pending, pulse reset_i → v_o=0, credit_v_o=0, credit_count_o=0; a subsequent write/read round-trip works.

Source files
------------

// File: rtl/bsg_flow_credit_receiver_pkg.sv
// rtl/bsg_flow_credit_receiver_pkg.sv - shared width helpers for the credit receiver
package bsg_flow_credit_receiver_pkg;

  // Counters must hold the full range 0..els inclusive.
  function automatic int count_width(input int els);
    return $clog2(els + 1);
  endfunction

  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_flow_credit_receiver_fifo.sv
// rtl/bsg_flow_credit_receiver_fifo.sv - els_p-entry receive FIFO (storage, pointers, occupancy)
// BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN adds the error_event_o flag.
module bsg_flow_credit_receiver_fifo
  import bsg_flow_credit_receiver_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p = 16,
  localparam int cnt_w = count_width(els_p),
  localparam int ptr_w = ptr_width(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               deq_o
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  , output logic             error_event_o
`endif
);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w-1:0]   occ;
  logic               full, wr;

  assign full   = (occ == cnt_w'(els_p));
  assign v_o    = (occ != '0);
  assign data_o = mem[rd_ptr];
  // A full FIFO refuses the write even if the head leaves this cycle.
  assign wr     = v_i & ~full;
  assign deq_o  = yumi_i & v_o;

`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  assign error_event_o = (v_i & full) | (yumi_i & ~v_o);
`endif

  always_ff @(posedge clk_i) begin
    if (wr) mem[wr_ptr] <= data_i;
  end

  // Power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr)    wr_ptr <= wr_ptr + 1'b1;
      if (deq_o) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + cnt_w'(wr) - cnt_w'(deq_o);
    end
  end

endmodule

// File: rtl/bsg_flow_credit_receiver.sv
// rtl/bsg_flow_credit_receiver.sv - credit receiver: FIFO plus batched credit return
// BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN adds the sticky error_o output.
module bsg_flow_credit_receiver
  import bsg_flow_credit_receiver_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p = 16,
  parameter int credit_batch_p = 4,
  localparam int cnt_w = count_width(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  input  logic               flush_i,
  output logic               credit_v_o,
  output logic [cnt_w-1:0]   credit_count_o,
  input  logic               credit_ready_i
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  , output logic             error_o
`endif
);

  localparam logic [cnt_w-1:0] batch = cnt_w'(credit_batch_p);

  logic             deq;
  logic [cnt_w-1:0] pending, load_amt;
  logic             slot_free, load;

`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  logic error_event;
`endif

  bsg_flow_credit_receiver_fifo #(
    .width_p(width_p),
    .els_p  (els_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i),
    .deq_o  (deq)
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    , .error_event_o(error_event)
`endif
  );

  // Load decision sees pending before this cycle's dequeue.
  always_comb begin
    slot_free = ~credit_v_o | credit_ready_i;
    load      = slot_free & ((pending >= batch) | (flush_i & (pending != '0)));
    load_amt  = flush_i ? pending : batch;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending        <= '0;
      credit_v_o     <= 1'b0;
      credit_count_o <= '0;
    end else begin
      pending <= pending - (load ? load_amt : '0) + cnt_w'(deq);
      if (load) begin
        credit_v_o     <= 1'b1;
        credit_count_o <= load_amt;
      end else if (credit_ready_i) begin
        credit_v_o     <= 1'b0;
        credit_count_o <= '0;
      end
    end
  end

`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)          error_o <= 1'b0;
    else if (error_event) error_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bsg_flow_credit_receiver.sv
// tb/tb_bsg_flow_credit_receiver.sv - randomized bench with queue-based reference model
// Also checks error_o when BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN is defined.
module tb_bsg_flow_credit_receiver;

  localparam int E = 16;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset_i, v_i, yumi_i, flush_i, credit_ready_i;
  logic [7:0] data_i;
  logic       v_o, credit_v_o;
  logic [7:0] data_o;
  logic [4:0] credit_count_o;
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
  logic       error_o;
`endif

  bsg_flow_credit_receiver #(.width_p(8), .els_p(E), .credit_batch_p(B)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .v_i           (v_i),
    .data_i        (data_i),
    .v_o           (v_o),
    .data_o        (data_o),
    .yumi_i        (yumi_i),
    .flush_i       (flush_i),
    .credit_v_o    (credit_v_o),
    .credit_count_o(credit_count_o),
    .credit_ready_i(credit_ready_i)
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    , .error_o     (error_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: buffered words, unreturned credits, current offer.
  logic [7:0] mq[$];
  int m_pend = 0, m_ov = 0, m_oc = 0, m_err = 0, m_free = E;
  int obs_ret = 0, w_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic y,
                      input logic f, input logic r, input logic rst);
    int n, amt;
    bit deq, wr;
    reset_i = rst; v_i = v; data_i = d; yumi_i = y; flush_i = f; credit_ready_i = r;
    @(negedge clk);
    n = mq.size();
    check("v_o", v_o, n != 0);
    if (n != 0) check("data_o", data_o, mq[0]);
    check("credit_v_o", credit_v_o, m_ov);
    check("credit_count_o", credit_count_o, m_oc);
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    check("error_o", error_o, m_err);
`endif
    if (credit_v_o && r) obs_ret += int'(credit_count_o);
    deq = y && n > 0;
    wr  = v && n < E;
    if ((v && n == E) || (y && n == 0)) m_err = 1;
    if (m_ov && r) m_free += m_oc;
    if ((!m_ov || r) && (m_pend >= B || (f && m_pend > 0))) begin
      amt = f ? m_pend : B;
      m_ov = 1; m_oc = amt; m_pend -= amt;
    end else if (r) begin
      m_ov = 0; m_oc = 0;
    end
    if (deq) begin m_pend++; void'(mq.pop_front()); end
    if (wr) begin mq.push_back(d); m_free--; w_cnt++; end
    if (rst) begin
      mq.delete();
      m_pend = 0; m_ov = 0; m_oc = 0; m_err = 0; m_free = E; obs_ret = 0; w_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic r);
    for (int i = 0; i < cycles; i++) step(0, 8'h00, 0, 0, r, 0);
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 0, 1, 1);
  endtask

  initial begin
    int ret0;
    do_reset();
    do_reset();
    check("rst_v_o", v_o, 0);
    check("rst_credit_v_o", credit_v_o, 0);
    check("rst_credit_count", credit_count_o, 0);

    // Pass-through
    step(1, 8'hA1, 0, 0, 1, 0);
    check("pt_v_o", v_o, 1);
    check("pt_data", data_o, 8'hA1);
    step(0, 8'h00, 1, 0, 1, 0);
    idle(3, 1);
    check("pt_no_credit", credit_v_o, 0);

    // Batching and latency
    do_reset();
    for (int i = 0; i < 5; i++) step(i < 4, 8'(8'h10 + i), i >= 1, 0, 1, 0);
    check("batch_t1", credit_v_o, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    check("batch_t2_v", credit_v_o, 1);
    check("batch_t2_count", credit_count_o, 4);
    idle(4, 1);
    check("batch_total", obs_ret, 4);

    // Backpressure with back-to-back reload
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, 0);
    check("bp_hold_count", credit_count_o, 4);
    step(0, 8'h00, 0, 0, 1, 0);
    check("bp_reload_v", credit_v_o, 1);
    idle(3, 1);
    check("bp_total", obs_ret, 8);

    // Flush
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 1, 0);
    idle(2, 1);
    check("fl_none", credit_v_o, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    check("fl_count", credit_count_o, 3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 1, 0);
    check("fl_empty", credit_v_o, 0);

    // Full: dropped writes, then drain
    do_reset();
    for (int i = 0; i < E; i++) step(1, 8'(i), 0, 0, 1, 0);
    step(1, 8'hFF, 0, 0, 1, 0);
`ifdef BSG_FLOW_CREDIT_RECEIVER_OVERFLOW_CHECK_EN
    check("ovf_error", error_o, 1);
`endif
    step(1, 8'hFF, 1, 0, 1, 0);
    for (int i = 0; i < E + 2; i++) step(0, 8'h00, 1, 0, 1, 0);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, 0);
    idle(2, 0);
    check("mid_offer", credit_v_o, 1);
    do_reset();
    check("mid_v_o", v_o, 0);
    check("mid_credit_v", credit_v_o, 0);
    check("mid_credit_count", credit_count_o, 0);
    step(1, 8'h5A, 0, 0, 1, 0);
    check("mid_rt_data", data_o, 8'h5A);
    step(0, 8'h00, 1, 0, 1, 0);

    // Randomized traffic, sender honours its credit count
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic v, y, f, r;
      v = (m_free > 0) && ($urandom_range(0, 2) != 0);
      y = (mq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) != 0);
      step(v, 8'($urandom), y, f, r, 0);
    end
    for (int i = 0; i < E + 2; i++) step(0, 8'h00, mq.size() > 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1, 1, 0);
    ret0 = E - w_cnt + obs_ret;
    check("rand_credits_home", ret0, E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
